// File: rtl/hc_sr04_pkg.sv
// Shared types and default timing for the HC-SR04 echo emulator (50 MHz clk).
package hc_sr04_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO
    } state_t;

    localparam int unsigned DEF_TRIG_MIN    = 500;
    localparam int unsigned DEF_TRIG_MAX    = 5000;
    localparam int unsigned DEF_BURST_CYC   = 10000;
    localparam int unsigned DEF_CYC_PER_CM  = 2979;
    localparam int unsigned DEF_MAX_CM      = 400;
    localparam int unsigned DEF_TIMEOUT_CYC = 1900000;

    localparam int unsigned ECHO_W = 21;
    localparam int unsigned CNT_W  = 14;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hc_sr04_echo_emu.sv
// HC-SR04 far-end emulator: validates a trigger pulse and answers with a distance-coded echo.
// Optional macro HC_SR04_EMU_JITTER_EN adds 0..15 cycles of LFSR jitter to the burst delay.
module hc_sr04_echo_emu
    import hc_sr04_pkg::*;
#(
    parameter int unsigned TRIG_MIN    = DEF_TRIG_MIN,
    parameter int unsigned TRIG_MAX    = DEF_TRIG_MAX,
    parameter int unsigned BURST_CYC   = DEF_BURST_CYC,
    parameter int unsigned CYC_PER_CM  = DEF_CYC_PER_CM,
    parameter int unsigned MAX_CM      = DEF_MAX_CM,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_in,
    input  logic [8:0] dist_cm,
    output logic       echo_out,
    output logic       busy,
    output logic       trig_err
);

    localparam logic [CNT_W-1:0]  TMIN    = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0]  TMAX    = CNT_W'(TRIG_MAX);
    localparam logic [CNT_W-1:0]  TSAT    = CNT_W'(TRIG_MAX + 1);
    localparam logic [CNT_W-1:0]  TBURST  = CNT_W'(BURST_CYC);
    localparam logic [ECHO_W-1:0] CPC     = ECHO_W'(CYC_PER_CM);
    localparam logic [ECHO_W-1:0] TIMEOUT = ECHO_W'(TIMEOUT_CYC);
    localparam logic [8:0]        MAX_D   = 9'(MAX_CM);

    state_t state, state_next;

    logic trig_s, trig_d, trig_rise, trig_fall;
    logic [CNT_W-1:0]  width_cnt, hi_cycles, burst_cnt, burst_tgt, burst_tgt_calc;
    logic [ECHO_W-1:0] echo_cnt, echo_w, w_calc;
    logic width_ok, accept, reject, echo_d;

    sync_2ff u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig_in),
        .q     (trig_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_d <= 1'b0;
        else        trig_d <= trig_s;
    end

    assign trig_rise = trig_s & ~trig_d;
    assign trig_fall = ~trig_s & trig_d;

    // The rise cycle that launched TRIG_HI is not in width_cnt, so add it back here.
    assign hi_cycles = width_cnt + CNT_W'(1);
    assign width_ok  = (hi_cycles >= TMIN) && (hi_cycles <= TMAX);

    assign w_calc = (dist_cm != 9'd0 && dist_cm <= MAX_D) ? ECHO_W'(dist_cm) * CPC : TIMEOUT;

`ifdef HC_SR04_EMU_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      lfsr <= 8'hA5;
        else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign burst_tgt_calc = TBURST + CNT_W'(lfsr[3:0]);
`else
    assign burst_tgt_calc = TBURST;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            echo_out <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            state    <= state_next;
            echo_out <= echo_d;
            trig_err <= reject;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (trig_rise) state_next = TRIG_HI;
            TRIG_HI: if (trig_fall) state_next = width_ok ? BURST : IDLE;
            BURST:   if (burst_cnt == burst_tgt) state_next = ECHO;
            ECHO:    if (echo_cnt == echo_w) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == TRIG_HI) && trig_fall && width_ok;
        reject = (state == TRIG_HI) && trig_fall && !width_ok;
        echo_d = (state_next == ECHO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_cnt <= '0;
            burst_cnt <= '0;
            burst_tgt <= '0;
            echo_cnt  <= '0;
            echo_w    <= '0;
        end else begin
            unique case (state)
                IDLE: width_cnt <= '0;
                TRIG_HI: begin
                    if (width_cnt != TSAT) width_cnt <= width_cnt + CNT_W'(1);
                    if (accept) begin
                        echo_w    <= w_calc;
                        burst_tgt <= burst_tgt_calc;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                    echo_cnt  <= ECHO_W'(1);
                end
                ECHO:    echo_cnt <= echo_cnt + ECHO_W'(1);
                default: width_cnt <= '0;
            endcase
        end
    end

endmodule
